// File: rtl/stream_read_responder.sv
// Stream-read source: buffers memory-side beats in a FIFO and serves consumer pops with registered data.
// Optional STREAM_RD_STATS_EN adds saturating push/pop/stall statistics counters.
module stream_read_responder #(
  parameter int AXI_DATA_W  = 64,
  parameter int FIFO_ADDR_W = 4,
  parameter int BEAT_CNT_W  = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [BEAT_CNT_W-1:0]  cfg_num_beats,
  output logic                   done,
  output logic                   busy,
  input  logic                   mem_wr_valid,
  input  logic [AXI_DATA_W-1:0]  mem_wr_data,
  output logic                   mem_wr_ready,
  output logic                   stream_read_ready,
  input  logic                   stream_read_req,
  output logic [AXI_DATA_W-1:0]  stream_read_data,
  output logic [FIFO_ADDR_W:0]   fifo_count,
  output logic                   err_underflow
`ifdef STREAM_RD_STATS_EN
  ,
  output logic [31:0]            stat_push_cnt,
  output logic [31:0]            stat_pop_cnt,
  output logic [31:0]            stat_stall_cnt
`endif
);

  localparam int DEPTH = 1 << FIFO_ADDR_W;
  localparam logic [BEAT_CNT_W-1:0]  ONE_BEAT  = BEAT_CNT_W'(1);
  localparam logic [BEAT_CNT_W-1:0]  ZERO_BEAT = BEAT_CNT_W'(0);
  localparam logic [FIFO_ADDR_W:0]   CNT_FULL  = (FIFO_ADDR_W+1)'(DEPTH);
  localparam logic [FIFO_ADDR_W:0]   CNT_ONE   = (FIFO_ADDR_W+1)'(1);
  localparam logic [FIFO_ADDR_W-1:0] PTR_ONE   = FIFO_ADDR_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [BEAT_CNT_W-1:0]  num_beats_q, num_beats_d;
  logic [BEAT_CNT_W-1:0]  pushed_q, pushed_d;
  logic [BEAT_CNT_W-1:0]  popped_q, popped_d;
  logic [FIFO_ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_ADDR_W:0]   count_q, count_d;
  logic [AXI_DATA_W-1:0]  rd_data_q, rd_data_d;
  logic                   err_q, err_d;
  logic [AXI_DATA_W-1:0]  mem_q [DEPTH];

  logic full_s, empty_s, push_s, pop_s;

  // Handshake qualifiers come from registered state only, never from same-cycle inputs.
  assign full_s            = (count_q == CNT_FULL);
  assign empty_s           = (count_q == {(FIFO_ADDR_W+1){1'b0}});
  assign mem_wr_ready      = (state_q == ST_ACTIVE) && !full_s && (pushed_q != num_beats_q);
  assign stream_read_ready = (state_q == ST_ACTIVE) && !empty_s;
  assign push_s            = mem_wr_valid && mem_wr_ready;
  assign pop_s             = stream_read_req && stream_read_ready;

  assign done              = (state_q == ST_DONE);
  assign busy              = (state_q == ST_ACTIVE);
  assign stream_read_data  = rd_data_q;
  assign fifo_count        = count_q;
  assign err_underflow     = err_q;

  // Next-state logic for the FSM, FIFO pointers, beat counters and data register.
  always_comb begin
    state_d     = state_q;
    num_beats_d = num_beats_q;
    pushed_d    = pushed_q;
    popped_d    = popped_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_data_d   = rd_data_q;
    err_d       = err_q;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      pushed_d = pushed_q + ONE_BEAT;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d  = rd_ptr_q + PTR_ONE;
      popped_d  = popped_q + ONE_BEAT;
      rd_data_d = mem_q[rd_ptr_q];
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    if (stream_read_req && !stream_read_ready) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          num_beats_d = cfg_num_beats;
          pushed_d    = ZERO_BEAT;
          popped_d    = ZERO_BEAT;
          state_d     = (cfg_num_beats == ZERO_BEAT) ? ST_DONE : ST_ACTIVE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        // Leave on the pop that brings the pop counter up to the transfer size.
        if (pop_s && ((popped_q + ONE_BEAT) == num_beats_q)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      num_beats_q <= ZERO_BEAT;
      pushed_q    <= ZERO_BEAT;
      popped_q    <= ZERO_BEAT;
      wr_ptr_q    <= {FIFO_ADDR_W{1'b0}};
      rd_ptr_q    <= {FIFO_ADDR_W{1'b0}};
      count_q     <= {(FIFO_ADDR_W+1){1'b0}};
      rd_data_q   <= {AXI_DATA_W{1'b0}};
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_beats_q <= num_beats_d;
      pushed_q    <= pushed_d;
      popped_q    <= popped_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_data_q   <= rd_data_d;
      err_q       <= err_d;
    end
  end

  // FIFO storage; contents are don't-care once the pointers are reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= mem_wr_data;
    end
  end

`ifdef STREAM_RD_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
  endfunction

  logic [31:0] stat_push_q, stat_pop_q, stat_stall_q;
  logic        stall_s;

  assign stall_s        = (state_q == ST_ACTIVE) && !stream_read_req && stream_read_ready;
  assign stat_push_cnt  = stat_push_q;
  assign stat_pop_cnt   = stat_pop_q;
  assign stat_stall_cnt = stat_stall_q;

  // Statistics survive start; only reset clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_push_q  <= 32'd0;
      stat_pop_q   <= 32'd0;
      stat_stall_q <= 32'd0;
    end else begin
      stat_push_q  <= push_s  ? sat_inc(stat_push_q)  : stat_push_q;
      stat_pop_q   <= pop_s   ? sat_inc(stat_pop_q)   : stat_pop_q;
      stat_stall_q <= stall_s ? sat_inc(stat_stall_q) : stat_stall_q;
    end
  end
`endif

endmodule

// File: tb/tb_stream_read_responder.sv
// Randomized and directed bench for stream_read_responder with a queue-based reference model and pop scoreboard.
module tb_stream_read_responder;
  logic        clk = 1'b0;
  logic        reset, start, mem_wr_valid, stream_read_req;
  logic [31:0] cfg_num_beats;
  logic [63:0] mem_wr_data, stream_read_data;
  logic        done, busy, mem_wr_ready, stream_read_ready, err_underflow;
  logic [4:0]  fifo_count;
`ifdef STREAM_RD_STATS_EN
  logic [31:0] stat_push_cnt, stat_pop_cnt, stat_stall_cnt;
`endif

  always #5 clk = ~clk;

  stream_read_responder dut (
    .clk(clk), .reset(reset), .start(start), .cfg_num_beats(cfg_num_beats),
    .done(done), .busy(busy), .mem_wr_valid(mem_wr_valid), .mem_wr_data(mem_wr_data),
    .mem_wr_ready(mem_wr_ready), .stream_read_ready(stream_read_ready),
    .stream_read_req(stream_read_req), .stream_read_data(stream_read_data),
    .fifo_count(fifo_count), .err_underflow(err_underflow)
`ifdef STREAM_RD_STATS_EN
    , .stat_push_cnt(stat_push_cnt), .stat_pop_cnt(stat_pop_cnt), .stat_stall_cnt(stat_stall_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference model: 0 idle, 1 active, 2 done; buffered beats kept in a plain queue.
  logic [63:0] mq[$];
  logic [63:0] sb[$];
  int          mstate = 0;
  int unsigned m_num = 0, m_pushed = 0, m_popped = 0;
  bit          m_err = 1'b0;
  logic [63:0] m_data = 64'd0;
  int unsigned m_spush = 0, m_spop = 0, m_sstall = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit rst, input bit st, input int unsigned c,
                      input bit v, input logic [63:0] d, input bit rq);
    bit wr_rdy, rd_rdy, push, pop;
    @(negedge clk);
    wr_rdy = (mstate == 1) && (mq.size() < 16) && (m_pushed != m_num);
    rd_rdy = (mstate == 1) && (mq.size() > 0);
    chk("done", {63'd0, done}, {63'd0, mstate == 2});
    chk("busy", {63'd0, busy}, {63'd0, mstate == 1});
    chk("wr_ready", {63'd0, mem_wr_ready}, {63'd0, wr_rdy});
    chk("rd_ready", {63'd0, stream_read_ready}, {63'd0, rd_rdy});
    chk("count", {59'd0, fifo_count}, 64'(mq.size()));
    chk("err", {63'd0, err_underflow}, {63'd0, m_err});
    chk("data", stream_read_data, m_data);
`ifdef STREAM_RD_STATS_EN
    chk("stat_push", {32'd0, stat_push_cnt}, 64'(m_spush));
    chk("stat_pop", {32'd0, stat_pop_cnt}, 64'(m_spop));
    chk("stat_stall", {32'd0, stat_stall_cnt}, 64'(m_sstall));
`endif
    reset = rst; start = st; cfg_num_beats = c; mem_wr_valid = v; mem_wr_data = d; stream_read_req = rq;
    if (rst) begin
      mstate = 0; mq.delete(); m_num = 0; m_pushed = 0; m_popped = 0;
      m_err = 1'b0; m_data = 64'd0; m_spush = 0; m_spop = 0; m_sstall = 0;
    end else begin
      push = v && wr_rdy;
      pop  = rq && rd_rdy;
      if (rq && !rd_rdy) m_err = 1'b1;
      if (mstate == 1 && !rq && rd_rdy) m_sstall++;
      if (pop) begin
        m_data = mq.pop_front();
        sb.push_back(m_data);
        m_popped++;
        m_spop++;
      end
      if (push) begin
        mq.push_back(d);
        m_pushed++;
        m_spush++;
      end
      if (mstate == 0) begin
        if (st) begin
          m_num = c; m_pushed = 0; m_popped = 0;
          mstate = (c == 0) ? 2 : 1;
        end
      end else if (mstate == 2) begin
        mstate = 0;
      end else if (pop && m_popped == m_num) begin
        mstate = 2;
      end
    end
  endtask

  task automatic finish_xfer(input int vpct, input int rpct);
    for (int i = 0; i < 4000 && mstate != 0; i++)
      step(1'b0, 1'b0, 0, ($urandom % 100) < vpct, {$urandom, $urandom}, ($urandom % 100) < rpct);
    if (mstate != 0) begin
      total++; bad++;
      $display("FAIL xfer_timeout: model state %0d expected 0", mstate);
    end
  endtask

  // Scoreboard monitor: every real pop must be matched by a queued expected beat.
  initial begin
    logic [63:0] exp;
    forever begin
      @(posedge clk);
      if (!reset && stream_read_req && stream_read_ready) begin
        #1;
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL pop_unexpected: got %0h expected no pop", stream_read_data);
        end else begin
          exp = sb.pop_front();
          chk("pop_data", stream_read_data, exp);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; cfg_num_beats = 32'd0; mem_wr_valid = 1'b0;
    mem_wr_data = 64'd0; stream_read_req = 1'b0;
    step(1'b1, 1'b0, 0, 1'b0, 64'd0, 1'b0);
    step(1'b0, 1'b0, 0, 1'b0, 64'd0, 1'b0);

    // Four beats with req held high.
    step(1'b0, 1'b1, 4, 1'b0, 64'd0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 0, 1'b1, 64'hA0 + 64'(i), 1'b1);
    finish_xfer(0, 100);

    // Fill to full, hold a blocked beat, one pop frees a slot.
    step(1'b1, 1'b0, 0, 1'b0, 64'd0, 1'b0);
    step(1'b0, 1'b1, 20, 1'b0, 64'd0, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 0, 1'b1, 64'h100 + 64'(i), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 1'b1, 64'h117, 1'b0);
    step(1'b0, 1'b0, 0, 1'b1, 64'h117, 1'b1);
    step(1'b0, 1'b0, 0, 1'b1, 64'h117, 1'b0);
    finish_xfer(80, 80);

    // Push and req together into an empty FIFO.
    step(1'b1, 1'b0, 0, 1'b0, 64'd0, 1'b0);
    step(1'b0, 1'b1, 1, 1'b0, 64'd0, 1'b0);
    step(1'b0, 1'b0, 0, 1'b1, 64'h33, 1'b1);
    step(1'b0, 1'b0, 0, 1'b0, 64'd0, 1'b1);
    finish_xfer(0, 0);

    // Zero-beat transfer never accepts a push.
    step(1'b0, 1'b1, 0, 1'b1, 64'h55, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 1'b1, 64'h55, 1'b0);

    // Reset in the middle of an 8-beat transfer, then a fresh transfer.
    step(1'b0, 1'b1, 8, 1'b0, 64'd0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 0, 1'b1, 64'hC0 + 64'(i), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 1'b0, 64'd0, 1'b1);
    step(1'b1, 1'b0, 0, 1'b0, 64'd0, 1'b0);
    step(1'b0, 1'b0, 0, 1'b0, 64'd0, 1'b0);
    step(1'b0, 1'b1, 2, 1'b0, 64'd0, 1'b0);
    finish_xfer(70, 70);

    // Randomized transfers, occasionally with start pulses inside the transfer.
    for (int t = 0; t < 30; t++) begin
      if (($urandom % 8) == 0) step(1'b1, 1'b0, 0, 1'b0, 64'd0, 1'b0);
      step(1'b0, 1'b1, $urandom_range(0, 40), 1'b0, 64'd0, 1'b0);
      for (int i = 0; i < 4 && mstate == 1; i++)
        step(1'b0, ($urandom % 2) == 1, $urandom_range(0, 5), 1'b1, {$urandom, $urandom}, 1'b0);
      finish_xfer($urandom_range(20, 100), $urandom_range(20, 100));
      step(1'b0, 1'b0, 0, 1'b0, 64'd0, ($urandom % 4) == 0);
    end

    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 1'b0, 64'd0, 1'b0);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
